// File: rtl/rnd_pack_buffer.sv
// Packs N_WORDS consecutive PRNG words into one wide randomness vector for the
// masked-gadget datapath; out_rnd and out_valid come straight from flops.
module rnd_pack_buffer #(
    parameter int IN_W    = 32,
    parameter int N_WORDS = 4,
    parameter int OUT_W   = IN_W * N_WORDS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_rnd,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CNT_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(N_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_NEXT = CNT_W'((N_WORDS > 1) ? 1 : 0);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    generate
        if (OUT_W != IN_W * N_WORDS) begin : g_bad_out_w
            $error("rnd_pack_buffer: OUT_W must equal IN_W*N_WORDS");
        end
        if (N_WORDS < 1) begin : g_bad_n_words
            $error("rnd_pack_buffer: N_WORDS must be at least 1");
        end
    endgenerate

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [OUT_W-1:0] pack_reg;
    logic             in_fire, out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FILL;
            cnt      <= '0;
            pack_reg <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            // In FULL a word can only arrive together with out_fire, and cnt is 0 there.
            if (in_fire) begin
                pack_reg[int'(cnt) * IN_W +: IN_W] <= in_data;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            FILL: begin
                if (in_fire) begin
                    if (cnt == LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = FULL;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            FULL: begin
                if (out_fire) begin
                    if (in_fire) begin
                        // Single-word vectors stay FULL so a vector can leave every cycle.
                        cnt_nxt   = CNT_NEXT;
                        state_nxt = (N_WORDS == 1) ? FULL : FILL;
                    end else begin
                        state_nxt = FILL;
                    end
                end
            end
            default: begin
                state_nxt = FILL;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        out_valid = (state == FULL);
        in_ready  = (state == FILL) | out_ready;
    end

    assign out_rnd = pack_reg;

endmodule

// File: tb/tb_rnd_pack_buffer.sv
// Directed and randomised bench for rnd_pack_buffer with a vector scoreboard;
// a second instance covers the single-word-per-vector configuration.
module tb_rnd_pack_buffer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0]  id;
    logic         iv, ir, ov, ordy;
    logic [127:0] ornd;

    logic [7:0]   id1;
    logic         iv1, ir1, ov1, ordy1;
    logic [7:0]   ornd1;

    rnd_pack_buffer #(.IN_W(32), .N_WORDS(4), .OUT_W(128)) dut (
        .clk(clk), .rst(rst),
        .in_data(id), .in_valid(iv), .in_ready(ir),
        .out_rnd(ornd), .out_valid(ov), .out_ready(ordy)
    );

    rnd_pack_buffer #(.IN_W(8), .N_WORDS(1), .OUT_W(8)) dut1 (
        .clk(clk), .rst(rst),
        .in_data(id1), .in_valid(iv1), .in_ready(ir1),
        .out_rnd(ornd1), .out_valid(ov1), .out_ready(ordy1)
    );

    int           n_assert = 0;
    int           n_fail   = 0;
    logic [127:0] sbq[$];
    logic [127:0] part     = '0;
    int           pcnt     = 0;
    bit           in_fired = 1'b0;
    bit           hold_prev = 1'b0;
    logic [127:0] rnd_prev = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, update the model, return #1 after the rising edge.
    task automatic cyc();
        @(negedge clk);
        in_fired = 1'b0;
        if (rst) begin
            sbq.delete();
            part      = '0;
            pcnt      = 0;
            hold_prev = 1'b0;
        end else begin
            if (hold_prev && ov) chk("hold_stable", ornd, rnd_prev);
            if (ov && ordy) begin
                if (sbq.size() == 0) chk("sb_size_on_output", 128'(sbq.size()), 128'd1);
                else chk("vector", ornd, sbq.pop_front());
            end
            if (iv && ir) begin
                part[pcnt*32 +: 32] = id;
                pcnt++;
                if (pcnt == 4) begin
                    sbq.push_back(part);
                    pcnt = 0;
                end
                in_fired = 1'b1;
            end
            hold_prev = ov && !ordy;
            rnd_prev  = ornd;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent;
        int guard;
        logic [127:0] exp_vec;

        rst = 1'b1; iv = 1'b0; id = '0; ordy = 1'b0;
        iv1 = 1'b0; id1 = '0; ordy1 = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            chk("idle_out_valid", 128'(ov), 128'd0);
            chk("idle_in_ready", 128'(ir), 128'd1);
            chk("idle_out_rnd", ornd, 128'd0);
            cyc();
        end

        // Fill with consumer stalled, then hold for 10 cycles
        for (int i = 0; i < 4; i++) begin
            iv = 1'b1;
            id = 32'h11111111 * (i + 1);
            cyc();
        end
        exp_vec = 128'h44444444_33333333_22222222_11111111;
        for (int i = 0; i < 10; i++) begin
            id = $urandom;
            chk("stall_out_valid", 128'(ov), 128'd1);
            chk("stall_in_ready", 128'(ir), 128'd0);
            chk("stall_out_rnd", ornd, exp_vec);
            cyc();
        end
        iv = 1'b0; ordy = 1'b1;
        cyc();
        ordy = 1'b0;
        chk("after_consume_valid", 128'(ov), 128'd0);

        // Continuous stream on both sides
        ordy = 1'b1;
        for (int w = 1; w <= 12; w++) begin
            iv = 1'b1;
            id = 32'(w);
            chk("stream_out_valid", 128'(ov), 128'((w > 1) && ((w - 1) % 4 == 0)));
            chk("stream_in_ready", 128'(ir), 128'd1);
            cyc();
        end
        iv = 1'b0;
        chk("stream_last_valid", 128'(ov), 128'd1);
        cyc();
        ordy = 1'b0;

        // Single-word vectors, both sides streaming
        iv1 = 1'b1; ordy1 = 1'b1; id1 = 8'hA0;
        chk("n1_first_valid", 128'(ov1), 128'd0);
        cyc();
        id1 = 8'hA1;
        chk("n1_valid_a", 128'(ov1), 128'd1);
        chk("n1_rnd_a0", 128'(ornd1), 128'hA0);
        chk("n1_in_ready_full", 128'(ir1), 128'd1);
        cyc();
        id1 = 8'hA2;
        chk("n1_valid_b", 128'(ov1), 128'd1);
        chk("n1_rnd_a1", 128'(ornd1), 128'hA1);
        cyc();
        iv1 = 1'b0;
        chk("n1_valid_c", 128'(ov1), 128'd1);
        chk("n1_rnd_a2", 128'(ornd1), 128'hA2);
        cyc();
        chk("n1_drained", 128'(ov1), 128'd0);
        ordy1 = 1'b0;

        // Reset in the middle of a fill
        iv = 1'b1; id = 32'hAAAAAAAA;
        cyc();
        id = 32'hBBBBBBBB;
        cyc();
        rst = 1'b1; id = 32'hCCCCCCCC;
        cyc();
        rst = 1'b0;
        chk("post_rst_rnd", ornd, 128'd0);
        chk("post_rst_valid", 128'(ov), 128'd0);
        for (int i = 0; i < 4; i++) begin
            id = 32'hC0DE0000 + 32'(i);
            cyc();
        end
        iv = 1'b0;
        chk("midrst_valid", 128'(ov), 128'd1);
        chk("midrst_rnd", ornd, 128'hC0DE0003_C0DE0002_C0DE0001_C0DE0000);
        cyc();
        ordy = 1'b1;
        cyc();
        ordy = 1'b0;

        // Randomised handshakes, 1000 words
        sent = 0; guard = 0; iv = 1'b0; in_fired = 1'b0;
        while (sent < 1000 && guard < 20000) begin
            if (!iv || in_fired) begin
                iv = 1'($urandom_range(0, 1));
                if (iv) id = $urandom;
            end
            ordy = 1'($urandom_range(0, 1));
            cyc();
            if (in_fired) sent++;
            guard++;
        end
        chk("random_words_sent", 128'(sent), 128'd1000);
        iv = 1'b0; ordy = 1'b1;
        repeat (4) cyc();
        chk("sb_drained", 128'(sbq.size()), 128'd0);
        chk("final_valid", 128'(ov), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
